fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the rv32i core; sits directly upstream of the controller/decode stage.
- Holds the fetch PC, issues one word read at a time to instruction memory over a valid/ready request plus valid-only response interface, and latches the returned word in an instruction register.
- Presents the word to decode as {opcode, func3, full instruction, pc} under a valid/ready handshake.
- Supports a redirect input for branches and jumps. At most one memory request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  byte address of requested word; bits [1:0] always 0.
- imem_rsp_valid  input  1  read data valid; memory never back-pressures the response.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  instruction register holds a word for decode.
- instr_ready  input  1  decode consumes the word this cycle.
- instr  output  32  instruction register.
- opcode  output  7  instr[6:0].
- func3  output  3  instr[14:12].
- pc  output  32  address the current instr was fetched from.
- redirect_valid  input  1  replace fetch PC; squash in-flight and held instruction.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC, pc=0, instr=32'h0000_0013 (addi x0,x0,0).
  - instr_valid=0, imem_req_valid=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards any outstanding request; the memory is reset by the same signal.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE -> REQ unconditionally on the first edge after reset release.
- REQ:
  - imem_req_valid=1, imem_addr=fetch_pc.
  - On imem_req_ready -> WAIT; otherwise stay in REQ.
- WAIT:
  - On imem_rsp_valid: instr<=imem_rsp_data, pc<=fetch_pc, -> HOLD.
- HOLD:
  - instr_valid=1.
  - On instr_ready: fetch_pc<=fetch_pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), -> REQ.
  - instr, pc, opcode and func3 stay stable until that handshake.
- DRAIN:
  - Waits for the response to a squashed request.
  - On imem_rsp_valid: data is dropped, instr is not written, -> REQ.
- Latency with zero-wait memory (ready=1, response one cycle after acceptance):
  - Request handshake in cycle N, response in N+1, instr_valid in N+2.
  - With decode always ready, the next request is issued in N+3, giving one instruction per 3 cycles.
- Redirect (redirect_valid=1) is applied at the edge and takes priority over every other event in the same cycle:
  - fetch_pc<={redirect_pc[31:2],2'b00}, and instr_valid drops next cycle.
  - IDLE: fetch_pc updated; -> REQ.
  - REQ, not accepted this cycle: -> REQ with the new address. This is the only case where imem_addr may change while imem_req_valid is high without ready.
  - REQ, accepted this cycle: -> DRAIN; the old response is dropped.
  - WAIT, no imem_rsp_valid: -> DRAIN.
  - WAIT with imem_rsp_valid in the same cycle: response dropped; -> REQ.
  - HOLD, with or without instr_ready: -> REQ; fetch_pc is redirect_pc, not +4.
  - DRAIN: fetch_pc updated; stay in DRAIN until the response arrives.
- imem_rsp_valid in IDLE, REQ or HOLD is a protocol violation: ignored, no state change. The assertion in the bench flags it.
- instr_ready while instr_valid=0 is ignored.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0013 at every address, instr_ready=1 -> requests at 0x0, 0x4, 0x8; instr_valid pulses every 3rd cycle with pc=0x0, 0x4, 0x8; opcode=7'b0010011, func3=3'b000.
- Decode stall: hold instr_ready=0 for 5 cycles with instr=32'h00500093 -> instr, pc and func3 stable, no new request. Release -> next request to pc+4.
- Memory back-pressure: imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 and imem_addr stays 0x0; accepted on the 4th cycle.
- Redirect while WAIT to redirect_pc=0x103 -> DRAIN. The late response 0xDEADBEEF never appears on instr. Next request addr=0x100; the returned word is presented with pc=0x100.
- Redirect in HOLD coincident with instr_ready, redirect_pc=0x40 -> next request addr=0x40, not pc+4. Also redirect in WAIT coincident with rsp_valid -> response dropped, REQ on the next cycle.
- RESET_PC=32'hFFFF_FFFC -> first fetch 0xFFFF_FFFC, second 0x0000_0000. Assert rst_n=0 mid-WAIT -> all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the rv32i core.
// Keeps the fetch PC and issues one word read at a time to instruction memory.
// Memory uses a valid/ready request and a valid-only response, and at most one
// request is outstanding. The returned word is latched in an instruction
// register and offered to decode under a valid/ready handshake. A redirect
// replaces the fetch PC and squashes both the in-flight word and the held word.
//
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   imem_req_valid/ready, imem_addr request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   response channel (never back-pressured)
//   instr_valid/ready               handshake to decode
//   instr, opcode, func3, pc        held word, decoded fields, fetch address
//   redirect_valid, redirect_pc     branch/jump target (bits [1:0] ignored)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;

    if (redirect_valid) begin
      // Redirect beats every other event this cycle. The held word is kept in
      // the register but is no longer valid. A request that is still in
      // flight must be drained before the next one can be issued.
      fetch_pc_d = redirect_target;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_req_ready ? DRAIN : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
        HOLD:    state_d = REQ;
        DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr_d = imem_rsp_data;
            pc_d    = fetch_pc_q;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign pc             = pc_q;

endmodule
